mem_ctrl: RTL

Memory controller that shares the single byte-wide RAM/IO port between instruction fetch (IF) and the MEM stage. It serialises word fetches and 1/2/4-byte loads and stores into per-byte RAM cycles, with MEM priority and flush-abort of fetches. It returns assembled data with single-cycle done pulses. It sits between IF/MEM and the external ram/io bus; its busy state feeds the stall controller alongside the ID load-use stall.

---
 rtl/mem_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises IF word fetches and MEM 1/2/4-byte loads/stores onto one byte-wide RAM/IO port.
// Optional feature macro MEMCTRL_IO_HOLD_EN: stall IO-region write strobes while io_buffer_full_i is high.
module mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int IO_BASE_BIT = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  input  logic [7:0]        mem_din_i,
  input  logic              io_buffer_full_i
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t            state, state_d;
  logic [2:0]        cnt, cnt_d;      // reads: issue index and (capture index + 1)
  logic [2:0]        nbytes;
  logic [2:0]        req_bytes;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] cur_addr, prev_addr;
  logic [31:0]       wdata, cap, cap_next, if_inst, mem_rdata;
  logic [1:0]        lane;
  logic              for_if;
  logic              accept_if, accept_mem, capture, load_out, io_stall;

  assign cur_addr  = base + ADDR_W'(cnt);
  assign prev_addr = cur_addr - ADDR_W'(1);
  assign lane      = cnt[1:0] - 2'd1;

  assign busy_o      = (state != IDLE);
  assign if_inst_o   = if_inst;
  assign mem_rdata_o = mem_rdata;

  always_comb begin
    unique case (mem_len_i)
      2'b00:   req_bytes = 3'd1;
      2'b01:   req_bytes = 3'd2;
      default: req_bytes = 3'd4;
    endcase
  end

  always_comb begin
    cap_next = cap;
    cap_next[{lane, 3'b000} +: 8] = mem_din_i;
  end

`ifdef MEMCTRL_IO_HOLD_EN
  assign io_stall = (cur_addr[IO_BASE_BIT -: 2] == 2'b11) && io_buffer_full_i;
`else
  logic io_full_unused;
  assign io_full_unused = io_buffer_full_i;
  assign io_stall       = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state;
    cnt_d      = cnt;
    accept_if  = 1'b0;
    accept_mem = 1'b0;
    capture    = 1'b0;
    load_out   = 1'b0;
    if_done_o  = 1'b0;
    mem_done_o = 1'b0;
    mem_a_o    = '0;
    mem_dout_o = '0;
    mem_wr_o   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rdy_in) begin
          if (mem_req_i) begin
            accept_mem = 1'b1;
            cnt_d      = '0;
            state_d    = mem_wr_i ? MEM_WR : MEM_RD;
          end else if (if_req_i && !flush_i) begin
            accept_if = 1'b1;
            cnt_d     = '0;
            state_d   = IF_RD;
          end
        end
      end
      IF_RD, MEM_RD: begin
        if (!rdy_in) begin
          // Re-present the address whose byte the replayed cycle captures, so mem_din_i is right on resume.
          if (cnt != 3'd0) mem_a_o = prev_addr;
        end else if (state == IF_RD && flush_i) begin
          state_d = IDLE;
        end else begin
          if (cnt < nbytes) mem_a_o = cur_addr;
          capture = (cnt != 3'd0);
          cnt_d   = cnt + 3'd1;
          if (cnt == nbytes) begin
            state_d  = DONE;
            load_out = 1'b1;
          end
        end
      end
      MEM_WR: begin
        mem_a_o    = cur_addr;
        mem_dout_o = wdata[{cnt[1:0], 3'b000} +: 8];
        if (rdy_in && !io_stall) begin
          mem_wr_o = 1'b1;
          cnt_d    = cnt + 3'd1;
          if (cnt == nbytes - 3'd1) state_d = DONE;
        end
      end
      DONE: begin
        if (rdy_in) begin
          if (for_if) if_done_o  = !flush_i;
          else        mem_done_o = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      cnt       <= '0;
      nbytes    <= '0;
      base      <= '0;
      wdata     <= '0;
      cap       <= '0;
      for_if    <= 1'b0;
      if_inst   <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept_mem) begin
        base   <= mem_addr_i;
        wdata  <= mem_wdata_i;
        nbytes <= req_bytes;
        for_if <= 1'b0;
        cap    <= '0;
      end else if (accept_if) begin
        base   <= if_addr_i;
        nbytes <= 3'd4;
        for_if <= 1'b1;
        cap    <= '0;
      end
      if (capture) cap <= cap_next;
      if (load_out) begin
        if (for_if) if_inst   <= cap_next;
        else        mem_rdata <= cap_next;
      end
    end
  end

endmodule
